// File: rtl/exc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : exc_pkg
// Purpose  : Shared types and encodings for the LEGv8 exception-control stage.
//            Defines the controller state enum, the exception-cause codes
//            that the decoder reports on EStatus, and the MRS source-select
//            encodings.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package exc_pkg;

  // Controller state. The explicit width keeps the state register 2 bits
  // wide regardless of tool defaults.
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    HANDLER = 2'd1,
    HALT    = 2'd2
  } exc_state_t;

  // Exception cause codes carried on EStatus / latched into ESR.
  localparam logic [3:0] ES_NONE     = 4'b0000;
  localparam logic [3:0] ES_IRQ      = 4'b0001;
  localparam logic [3:0] ES_NOTINSTR = 4'b0010;

  // MRS source selection. The remaining code reads as zero.
  localparam logic [1:0] MRS_ELR  = 2'b00;
  localparam logic [1:0] MRS_ESR  = 2'b01;
  localparam logic [1:0] MRS_ECNT = 2'b10;
  localparam logic [1:0] MRS_ZERO = 2'b11;

endpackage : exc_pkg
`default_nettype wire

// File: rtl/exc_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : exc_ctrl_if
// Purpose  : Bundles the decoder / fetch / MRS side signals of the exception
//            controller. The controller connects through the slave modport;
//            the surrounding pipeline (or a bench) drives the master side.
// Signals  :
//   IRQReq    master->slave  raw external interrupt request (level)
//   ExtIRQ    slave->master  masked pending interrupt to the decoder
//   IRQAck    slave->master  one-cycle pulse, interrupt taken
//   Exc       master->slave  exception reported by the decoder
//   EStatus   master->slave  exception cause (4 bits)
//   ERet      master->slave  ERET decoded
//   PC        master->slave  PC of the instruction in decode
//   MrsSel    master->slave  MRS source select
//   MrsData   slave->master  selected exception register, zero-extended
//   Redirect  slave->master  fetch must load Target next cycle
//   Target    slave->master  redirect address (zero when no redirect)
//   InHandler slave->master  controller is in HANDLER
//   Halted    slave->master  controller is in HALT
// Revision : 1.0 - initial release
// ============================================================================
interface exc_ctrl_if #(
  parameter int N = 64
);

  logic         IRQReq;
  logic         ExtIRQ;
  logic         IRQAck;
  logic         Exc;
  logic [3:0]   EStatus;
  logic         ERet;
  logic [N-1:0] PC;
  logic [1:0]   MrsSel;
  logic [N-1:0] MrsData;
  logic         Redirect;
  logic [N-1:0] Target;
  logic         InHandler;
  logic         Halted;

  // Pipeline / environment side.
  modport master (
    output IRQReq, Exc, EStatus, ERet, PC, MrsSel,
    input  ExtIRQ, IRQAck, MrsData, Redirect, Target, InHandler, Halted
  );

  // Exception controller side.
  modport slave (
    input  IRQReq, Exc, EStatus, ERet, PC, MrsSel,
    output ExtIRQ, IRQAck, MrsData, Redirect, Target, InHandler, Halted
  );

endinterface : exc_ctrl_if
`default_nettype wire

// File: rtl/exc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : exc_ctrl
// Purpose  : Exception-control stage wrapped around the LEGv8 main decoder.
//            Latches and masks external interrupts for the decoder, records
//            ELR / ESR / ECNT when an exception is taken, redirects fetch to
//            the exception vector or back to ELR, and serves MRS reads of the
//            exception registers.
// Ports    :
//   clk    in   system clock
//   reset  in   synchronous active-low reset
//   bus    slave modport of exc_ctrl_if (decoder, fetch and MRS signals)
// Parameters:
//   N       datapath / PC width
//   VECTOR  exception handler entry address
//   CNT_W   width of the saturating exception counter ECNT
// Revision : 1.0 - initial release
// ============================================================================
module exc_ctrl
  import exc_pkg::*;
#(
  parameter int           N      = 64,
  parameter logic [N-1:0] VECTOR = 64'h0000_0000_0000_00D8,
  parameter int           CNT_W  = 16
) (
  input  wire logic  clk,
  input  wire logic  reset,
  exc_ctrl_if.slave  bus
);

  // --------------------------------------------------------------------------
  // State and architectural registers
  // --------------------------------------------------------------------------
  exc_state_t         r_state;
  exc_state_t         w_state_nxt;

  logic [N-1:0]       r_elr;
  logic [3:0]         r_esr;
  logic [CNT_W-1:0]   r_ecnt;
  logic               r_irq_pend;

  // --------------------------------------------------------------------------
  // Event decode
  // --------------------------------------------------------------------------
  logic               w_in_run;
  logic               w_in_handler;
  logic               w_in_halt;
  logic               w_take;       // exception accepted while running
  logic               w_irq_take;   // accepted exception is the interrupt
  logic               w_ecnt_full;

  assign w_in_run     = (r_state == RUN);
  assign w_in_handler = (r_state == HANDLER);
  assign w_in_halt    = (r_state == HALT);

  assign w_take       = w_in_run & bus.Exc;
  assign w_irq_take   = w_take & (bus.EStatus == ES_IRQ);
  assign w_ecnt_full  = (r_ecnt == {CNT_W{1'b1}});

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic. Exc always wins over ERet; a fault inside the
  // handler is unrecoverable and parks the controller in HALT.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN: begin
        if (bus.Exc) begin
          w_state_nxt = HANDLER;
        end
      end
      HANDLER: begin
        if (bus.Exc) begin
          w_state_nxt = HALT;
        end else if (bus.ERet) begin
          w_state_nxt = RUN;
        end
      end
      HALT: begin
        w_state_nxt = HALT;
      end
      default: begin
        w_state_nxt = RUN;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output logic. Redirect/IRQAck are forced low while reset is
  // asserted so that stray decoder activity during reset never reaches
  // fetch. Target is kept at zero whenever no redirect is issued.
  // --------------------------------------------------------------------------
  logic               w_redirect;
  logic [N-1:0]       w_target;
  logic               w_irq_ack;

  always_comb begin
    w_redirect = 1'b0;
    w_target   = '0;
    w_irq_ack  = 1'b0;
    if (reset) begin
      case (r_state)
        RUN: begin
          if (bus.Exc) begin
            w_redirect = 1'b1;
            w_target   = VECTOR;
            w_irq_ack  = (bus.EStatus == ES_IRQ);
          end
        end
        HANDLER: begin
          if (bus.ERet && !bus.Exc) begin
            w_redirect = 1'b1;
            w_target   = r_elr;
          end
        end
        default: begin
          w_redirect = 1'b0;
        end
      endcase
    end
  end

  assign bus.Redirect  = w_redirect;
  assign bus.Target    = w_target;
  assign bus.IRQAck    = w_irq_ack;
  assign bus.InHandler = w_in_handler;
  assign bus.Halted    = w_in_halt;

  // Interrupts stay pending while masked; only RUN exposes them.
  assign bus.ExtIRQ    = r_irq_pend & w_in_run;

  // --------------------------------------------------------------------------
  // Exception registers. Only an exception accepted in RUN writes them; a
  // nested fault or ERET leaves the saved context intact.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_elr  <= '0;
      r_esr  <= ES_NONE;
      r_ecnt <= '0;
    end else if (w_take) begin
      r_elr <= bus.PC;
      r_esr <= bus.EStatus;
      if (!w_ecnt_full) begin
        r_ecnt <= r_ecnt + CNT_W'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Interrupt pending latch. Taking the interrupt clears it even if IRQReq
  // is still high in that cycle; a held request re-arms it one edge later.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_irq_pend <= 1'b0;
    end else if (w_irq_take) begin
      r_irq_pend <= 1'b0;
    end else if (bus.IRQReq) begin
      r_irq_pend <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // MRS read port. Reads the current register contents, so a write made by
  // an exception in this same cycle becomes visible from the next cycle on.
  // --------------------------------------------------------------------------
  logic [N-1:0]       w_mrs_data;

  always_comb begin
    w_mrs_data = '0;
    case (bus.MrsSel)
      MRS_ELR:  w_mrs_data = r_elr;
      MRS_ESR:  w_mrs_data = {{(N-4){1'b0}}, r_esr};
      MRS_ECNT: w_mrs_data = {{(N-CNT_W){1'b0}}, r_ecnt};
      default:  w_mrs_data = '0;
    endcase
  end

  assign bus.MrsData = w_mrs_data;

endmodule : exc_ctrl
`default_nettype wire

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- Exception-control stage for the LEGv8 CPU with exceptions.
- Sits directly around the main decoder:
  - Upstream: it feeds the decoder's ExtIRQ input with a latched, masked interrupt request.
  - Downstream: it consumes the decoder's Exc, EStatus and ERet outputs.
- Holds the architectural exception registers ELR, ESR and ECNT, and generates the PC redirect to the exception vector or back to ELR.
- Serves MRS reads of ELR, ESR and ECNT.

Parameters:
- N, 64, datapath and PC width.
- VECTOR, 64'h0000_0000_0000_00D8, exception handler entry address.
- CNT_W, 16, width of the exception counter ECNT.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset (reset==0 resets on the clk rising edge)
- IRQReq  in  1  raw external interrupt request, level
- ExtIRQ  out  1  masked pending interrupt, to the decoder
- IRQAck  out  1  one-cycle pulse: interrupt taken
- Exc  in  1  exception from the decoder
- EStatus  in  4  cause from the decoder
- ERet  in  1  ERET decoded
- PC  in  N  PC of the instruction currently being decoded
- MrsSel  in  2  MRS source: 00 ELR, 01 ESR, 10 ECNT, 11 zero
- MrsData  out  N  zero-extended selected register
- Redirect  out  1  PC must load Target next cycle
- Target  out  N  redirect address
- InHandler  out  1  state==HANDLER
- Halted  out  1  state==HALT

Behaviour:
- Reset (reset==0 at a clk edge), all taking effect at that edge:
  - state=RUN, ELR=0, ESR=0, ECNT=0, irq_pend=0.
  - Outputs Redirect=0, IRQAck=0, ExtIRQ=0, Target=0, MrsData=0 (MrsSel=00), InHandler=0, Halted=0.
  - Reset has priority over every other event, including mid-handler and in HALT.
- irq_pend:
  - Set on any edge where IRQReq==1.
  - Cleared on the edge where an exception with EStatus==4'b0001 is taken.
  - If clear and set coincide, clear wins; a still-high IRQReq re-sets irq_pend on the following edge.
- ExtIRQ = irq_pend & (state==RUN). This is combinational, so an interrupt is masked in HANDLER and HALT but stays pending.
- States RUN, HANDLER, HALT (enum in the package).
- RUN, Exc==1:
  - Next state HANDLER; ELR<=PC; ESR<=EStatus; ECNT<=ECNT+1, saturating at all-ones.
  - Same cycle, combinational: Redirect=1, Target=VECTOR.
  - If EStatus==4'b0001, IRQAck=1 for that cycle.
- RUN, ERet==1 and Exc==0: no-op. No redirect, no register change.
- HANDLER, ERet==1 and Exc==0:
  - Next state RUN.
  - Same cycle: Redirect=1, Target=ELR (value before the edge).
  - ELR, ESR and ECNT are unchanged.
- HANDLER, Exc==1 (nested fault): next state HALT; ELR, ESR and ECNT unchanged; Redirect=0.
- Exc has priority over ERet when both are 1.
- HALT: absorbing until reset. Redirect=0, IRQAck=0.
- Redirect is a single-cycle pulse per event, with no handshake. The fetch stage must consume it in that cycle.
- MrsData is combinational from the current registers.
  - A same-cycle exception write is not forwarded; the new value is visible from the next cycle.
  - ESR and ECNT are zero-extended to N bits.
- Target=0 whenever Redirect==0.

Decomposition:
- Package exc_pkg holds:
  - typedef enum logic [1:0] {RUN, HANDLER, HALT} exc_state_t;
  - localparams ES_NONE=4'b0000, ES_IRQ=4'b0001, ES_NOTINSTR=4'b0010;
  - MrsSel encodings MRS_ELR, MRS_ESR, MRS_ECNT.
- No sub-module is required. The saturating counter may be split into sat_counter #(CNT_W) if reused.

Test Plan:
- Reset low for 2 cycles with IRQReq=1 and Exc=1 -> every output 0, state RUN, irq_pend=0 after the edge.
- RUN, PC=64'h40, Exc=1, EStatus=0010:
  - Same cycle: Redirect=1, Target=64'hD8, IRQAck=0.
  - Next cycle: InHandler=1; MrsSel=00 gives 64'h40, 01 gives 64'h2, 10 gives 64'h1.
- IRQReq pulsed for 1 cycle in RUN:
  - ExtIRQ=1 next cycle.
  - Drive Exc=1, EStatus=0001, PC=64'h80 -> IRQAck=1, Redirect=1, then ExtIRQ=0 and ESR=1.
- In HANDLER, hold IRQReq=1 -> ExtIRQ stays 0. Then ERet=1 -> Redirect=1, Target=64'h80; ExtIRQ=1 the cycle after returning to RUN.
- In HANDLER, Exc=1 and ERet=1 together -> Halted=1, Redirect=0, ELR and ESR unchanged. Further ERet has no effect; reset low returns to RUN.
- RUN, ERet=1 -> Redirect=0 and no register change. Also take 65536 exceptions, each followed by ERet -> ECNT saturates at 16'hFFFF.
